// File: rtl/demux_route_buffer_if.sv
// Byte-routing bus: producer side (data, select, valid/ready) and two consumer legs.
// The producer holds the master view; the route buffer holds the slave view.
interface demux_route_buffer_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] in;
   logic             select;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] outA;
   logic             outA_valid;
   logic             outA_ready;
   logic [WIDTH-1:0] outB;
   logic             outB_valid;
   logic             outB_ready;
   logic [CW-1:0]    countA;
   logic [CW-1:0]    countB;

   modport master (
      output in, select, in_valid, outA_ready, outB_ready,
      input  in_ready, outA, outA_valid, outB, outB_valid, countA, countB
   );

   modport slave (
      input  in, select, in_valid, outA_ready, outB_ready,
      output in_ready, outA, outA_valid, outB, outB_valid, countA, countB
   );
endinterface

// File: rtl/demux_route_buffer.sv
// Steers each accepted byte into one of two independent FIFOs (A: select=0, B: select=1).
// Each leg shows its head word, or zero when empty; push-to-visible latency is one cycle.
module demux_route_buffer #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input logic                 clk,
   input logic                 reset,
   demux_route_buffer_if.slave bus
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] head_w  [2];
   logic [CW-1:0]    count_w [2];
   logic [1:0]       full_w;
   logic [1:0]       valid_w;
   logic [1:0]       out_ready_w;

   assign out_ready_w = {bus.outB_ready, bus.outA_ready};

   // Depends only on select and registered counts: a full FIFO refuses even while popping.
   assign bus.in_ready = bus.select ? ~full_w[1] : ~full_w[0];

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_chan
         logic [WIDTH-1:0] mem_q [DEPTH];
         logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
         logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
         logic [CW-1:0]    count_q, count_d;
         logic             push;
         logic             pop;

         assign full_w[gi]  = (count_q == CW'(DEPTH));
         assign valid_w[gi] = (count_q != '0);
         assign push        = bus.in_valid & (bus.select == 1'(gi)) & ~full_w[gi];
         assign pop         = valid_w[gi] & out_ready_w[gi];

         always_comb begin
            rd_ptr_d = rd_ptr_q;
            wr_ptr_d = wr_ptr_q;
            count_d  = count_q;
            if (push) begin
               wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
            end
            if (pop) begin
               rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
            end
            case ({push, pop})
               2'b10:   count_d = count_q + CW'(1);
               2'b01:   count_d = count_q - CW'(1);
               default: count_d = count_q;
            endcase
         end

         always_ff @(posedge clk) begin
            if (reset) begin
               rd_ptr_q <= '0;
               wr_ptr_q <= '0;
               count_q  <= '0;
            end else begin
               rd_ptr_q <= rd_ptr_d;
               wr_ptr_q <= wr_ptr_d;
               count_q  <= count_d;
            end
         end

         // Storage is never cleared; an empty count masks stale contents.
         always_ff @(posedge clk) begin
            if (push && !reset) begin
               mem_q[wr_ptr_q] <= bus.in;
            end
         end

         assign head_w[gi]  = valid_w[gi] ? mem_q[rd_ptr_q] : '0;
         assign count_w[gi] = count_q;
      end
   endgenerate

   assign bus.outA       = head_w[0];
   assign bus.outB       = head_w[1];
   assign bus.outA_valid = valid_w[0];
   assign bus.outB_valid = valid_w[1];
   assign bus.countA     = count_w[0];
   assign bus.countB     = count_w[1];
endmodule

// File: tb/tb_demux_route_buffer.sv
// Directed plus short random stimulus; per-leg queues predict heads, counts and in_ready.
module tb_demux_route_buffer;
   localparam int WIDTH = 8;
   localparam int DEPTH = 2;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_err;

   logic [WIDTH-1:0] qa[$];
   logic [WIDTH-1:0] qb[$];

   demux_route_buffer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   demux_route_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_state(input string tag);
      logic [WIDTH-1:0] ea;
      logic [WIDTH-1:0] eb;
      ea = (qa.size() != 0) ? qa[0] : '0;
      eb = (qb.size() != 0) ? qb[0] : '0;
      chk({tag, ".outA"},       32'(bus.outA),       32'(ea));
      chk({tag, ".outA_valid"}, 32'(bus.outA_valid), 32'(qa.size() != 0));
      chk({tag, ".countA"},     32'(bus.countA),     32'(qa.size()));
      chk({tag, ".outB"},       32'(bus.outB),       32'(eb));
      chk({tag, ".outB_valid"}, 32'(bus.outB_valid), 32'(qb.size() != 0));
      chk({tag, ".countB"},     32'(bus.countB),     32'(qb.size()));
   endtask

   // One clock: drive at negedge, check in_ready, clock, update model, check state.
   task automatic step(input string tag, input bit v, input bit s, input logic [WIDTH-1:0] d,
                       input bit ra, input bit rb, input bit rst);
      bit mready;
      bit push;
      bit pop_a;
      bit pop_b;
      reset          = rst;
      bus.in_valid   = v;
      bus.select     = s;
      bus.in         = d;
      bus.outA_ready = ra;
      bus.outB_ready = rb;
      #1;
      mready = s ? (qb.size() != DEPTH) : (qa.size() != DEPTH);
      if (!rst) chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'(mready));
      push  = v && mready;
      pop_a = ra && (qa.size() != 0);
      pop_b = rb && (qb.size() != 0);
      @(posedge clk);
      if (rst) begin
         qa.delete();
         qb.delete();
      end else begin
         if (pop_a) void'(qa.pop_front());
         if (pop_b) void'(qb.pop_front());
         if (push) begin
            if (s) qb.push_back(d);
            else   qa.push_back(d);
         end
      end
      @(negedge clk);
      chk_state(tag);
      $display("step %s: v=%0d sel=%0d in=%02h ra=%0d rb=%0d rst=%0d -> cA=%0d cB=%0d outA=%02h outB=%02h",
               tag, v, s, d, ra, rb, rst, bus.countA, bus.countB, bus.outA, bus.outB);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      reset = 1'b1;
      bus.in_valid = 1'b0;
      bus.select = 1'b0;
      bus.in = '0;
      bus.outA_ready = 1'b0;
      bus.outB_ready = 1'b0;
      @(negedge clk);

      step("rst0", 0, 0, 8'h00, 0, 0, 1);
      step("rst1", 0, 0, 8'h00, 0, 0, 1);

      // 1: first push visible next cycle
      step("t1_push5A", 1, 0, 8'h5A, 0, 0, 0);
      chk("t1_outA_direct", 32'(bus.outA), 32'h5A);
      step("t1_pop", 0, 0, 8'h00, 1, 0, 0);

      // 2: fill A, refused third push, B still open
      step("t2_push11", 1, 0, 8'h11, 0, 0, 0);
      step("t2_push22", 1, 0, 8'h22, 0, 0, 0);
      step("t2_refuse", 1, 0, 8'h99, 0, 0, 0);
      chk("t2_countA_full", 32'(bus.countA), 32'd2);
      step("t2_selB", 0, 1, 8'h00, 0, 0, 0);

      // 3: full with pop refuses push, then wrap
      step("t3_fullpop", 1, 0, 8'h44, 1, 0, 0);
      chk("t3_outA_22", 32'(bus.outA), 32'h22);
      step("t3_push33", 1, 0, 8'h33, 0, 0, 0);

      // 4: push B while popping A
      step("t4_pushB", 1, 1, 8'hC3, 1, 0, 0);
      chk("t4_outB_C3", 32'(bus.outB), 32'hC3);
      chk("t4_outA_33", 32'(bus.outA), 32'h33);

      // 5: steady stream on A at count=1
      for (int i = 0; i < 8; i++) begin
         step("t5_stream", 1, 0, 8'(8'hA0 + i), 1, 0, 0);
      end
      chk("t5_last", 32'(bus.outA), 32'hA7);

      // drain B and underflow attempt
      step("ub_popB", 0, 0, 8'h00, 0, 1, 0);
      step("ub_popB_empty", 0, 0, 8'h00, 0, 1, 0);

      // 6: reset with data held and in_valid high
      step("t6_fillA", 1, 0, 8'h5C, 0, 0, 0);
      step("t6_fillB0", 1, 1, 8'h6D, 0, 0, 0);
      step("t6_fillB1", 1, 1, 8'h7E, 0, 0, 0);
      step("t6_reset", 1, 1, 8'h77, 1, 1, 1);
      step("t6_emptypop", 0, 0, 8'h00, 1, 0, 0);
      chk("t6_countA_zero", 32'(bus.countA), 32'd0);

      // short random mix
      for (int i = 0; i < 60; i++) begin
         step("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end
endmodule
